// File: rtl/dmem_if.sv
// Data-memory port between the core (master) and the memory responder (slave).
// The err wire exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        busy;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err;

  modport master (output req, we, a, wd, input rd, ready, busy, err);
  modport slave  (input req, we, a, wd, output rd, ready, busy, err);
`else
  modport master (output req, we, a, wd, input rd, ready, busy);
  modport slave  (input req, we, a, wd, output rd, ready, busy);
`endif
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with WAIT_CYCLES wait states and a one-cycle ready pulse.
// Optional macro DMEM_ALIGN_CHECK_EN adds the err output and suppresses misaligned accesses.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   reset_n,
  dmem_if.slave bus
);
  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam int         AW       = DEPTH_LOG2 + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state, next_state;
  logic [3:0]      cnt;
  logic            accept;

  logic            we_p0;
  logic [AW-1:0]   addr_p0;
  logic [31:0]     wd_p0;

  logic            enter_resp, ready_d, busy_d;
  logic            acc_we;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     acc_wd;
  logic            misaligned;

  logic [31:0]     mem [WORDS];
  logic [31:0]     rd_q;
  logic            ready_q, busy_q;

  // A new request is only taken in IDLE or in the RESP cycle; WAIT ignores req.
  assign accept = (state != S_WAIT) && bus.req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_RESP: begin
        if (bus.req) next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        else         next_state = S_IDLE;
      end
      S_WAIT: if (cnt == 4'd0) next_state = S_RESP;
      default: next_state = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so the
  // live request fields are used instead of the captured ones.
  always_comb begin
    enter_resp = (next_state == S_RESP);
    ready_d    = enter_resp;
    busy_d     = (next_state != S_IDLE);
    if (state == S_WAIT) begin
      acc_we   = we_p0;
      acc_addr = addr_p0;
      acc_wd   = wd_p0;
    end else begin
      acc_we   = bus.we;
      acc_addr = bus.a[AW-1:0];
      acc_wd   = bus.wd;
    end
  end

  // p0: request capture and wait-state counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      we_p0   <= 1'b0;
      addr_p0 <= '0;
      wd_p0   <= '0;
    end else if (accept) begin
      cnt     <= CNT_INIT;
      we_p0   <= bus.we;
      addr_p0 <= bus.a[AW-1:0];
      wd_p0   <= bus.wd;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  logic unused_bits;

  assign misaligned  = (acc_addr[1:0] != 2'b00);
  assign unused_bits = ^bus.a[31:AW];
`else
  logic unused_bits;

  assign misaligned  = 1'b0;
  assign unused_bits = ^{bus.a[31:AW], acc_addr[1:0]};
`endif

  // p1: commit; memory contents survive reset
  always_ff @(posedge clk) begin
    if (reset_n && enter_resp && acc_we && !misaligned)
      mem[acc_addr[AW-1:2]] <= acc_wd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      if (enter_resp && !acc_we)
        rd_q <= misaligned ? 32'h0 : mem[acc_addr[AW-1:2]];
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= enter_resp && misaligned;
  end

  assign bus.err = err_q;
`endif

  assign bus.rd    = rd_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with W=2, W=3 and W=0 instances.
// Alignment scenarios run only when DMEM_ALIGN_CHECK_EN is defined.
module tb_dmem_responder;
  logic clk;
  logic rst_n2, rst_n3, rst_n0;
  int   n_vec;
  int   n_bad;

  dmem_if b2();
  dmem_if b3();
  dmem_if b0();

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u2 (.clk(clk), .reset_n(rst_n2), .bus(b2));
  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(3)) u3 (.clk(clk), .reset_n(rst_n3), .bus(b3));
  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset_n(rst_n0), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue2(input logic w, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    b2.req = 1'b1; b2.we = w; b2.a = addr; b2.wd = data;
    @(posedge clk); #1;
    b2.req = 1'b0;
  endtask

  task automatic issue3(input logic w, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    b3.req = 1'b1; b3.we = w; b3.a = addr; b3.wd = data;
    @(posedge clk); #1;
    b3.req = 1'b0;
  endtask

  task automatic store2(input logic [31:0] addr, input logic [31:0] data);
    issue2(1'b1, addr, data);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n2 = 1'b0; rst_n3 = 1'b0; rst_n0 = 1'b0;
    b2.req = 1'b1; b2.we = 1'b0; b2.a = 32'h0; b2.wd = 32'h0;
    b3.req = 1'b0; b3.we = 1'b0; b3.a = 32'h0; b3.wd = 32'h0;
    b0.req = 1'b1; b0.we = 1'b0; b0.a = 32'h0; b0.wd = 32'h0;
    repeat (3) @(negedge clk);
    if (b2.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready2 got %b want 0", b2.ready); end
    n_vec++;
    if (b2.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy2 got %b want 0", b2.busy); end
    n_vec++;
    if (b2.rd !== 32'h0) begin n_bad++; $display("FAIL reset_rd2 got %h want 0", b2.rd); end
    n_vec++;
    if (b3.busy !== 1'b0 || b3.ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_u3 got busy=%b ready=%b want 0/0", b3.busy, b3.ready);
    end
    n_vec++;
    if (b0.ready !== 1'b0 || b0.busy !== 1'b0 || b0.rd !== 32'h0) begin
      n_bad++; $display("FAIL reset_u0 got ready=%b busy=%b rd=%h want 0/0/0", b0.ready, b0.busy, b0.rd);
    end
    n_vec++;
`ifdef DMEM_ALIGN_CHECK_EN
    if (b2.err !== 1'b0) begin n_bad++; $display("FAIL reset_err2 got %b want 0", b2.err); end
    n_vec++;
`endif
    b2.req = 1'b0; b0.req = 1'b0;
    rst_n2 = 1'b1; rst_n3 = 1'b1; rst_n0 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store_load;
    logic exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    issue2(1'b1, 32'h10, 32'hDEADBEEF);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (b2.ready !== exp_r[t] || b2.busy !== exp_b[t]) begin
        n_bad++;
        $display("FAIL store_timing t=%0d got ready=%b busy=%b want %b/%b", t, b2.ready, b2.busy, exp_r[t], exp_b[t]);
      end
      n_vec++;
    end
    issue2(1'b0, 32'h10, 32'h0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (b2.ready !== exp_r[t] || b2.busy !== exp_b[t]) begin
        n_bad++;
        $display("FAIL load_timing t=%0d got ready=%b busy=%b want %b/%b", t, b2.ready, b2.busy, exp_r[t], exp_b[t]);
      end
      n_vec++;
      if (t == 2) begin
        if (b2.rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_rd got %h want deadbeef", b2.rd); end
        n_vec++;
      end
    end
  endtask

  task automatic test_aliasing;
    store2(32'h104, 32'hA5A5A5A5);
    if (b2.rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_hold got %h want deadbeef", b2.rd); end
    n_vec++;
    issue2(1'b0, 32'h004, 32'h0);
    repeat (3) @(negedge clk);
    if (b2.ready !== 1'b1 || b2.rd !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL alias_rd got ready=%b rd=%h want 1/a5a5a5a5", b2.ready, b2.rd);
    end
    n_vec++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int idx;
    logic er;
    store2(32'h0, 32'd1);
    store2(32'h4, 32'd2);
    store2(32'h8, 32'd3);
    @(posedge clk); #1;
    b2.req = 1'b1; b2.we = 1'b0; b2.a = 32'h0;
    @(posedge clk);
    idx = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      er = (t % 3 == 2);
      if (b2.ready !== er || b2.busy !== (t < 9)) begin
        n_bad++;
        $display("FAIL b2b_timing t=%0d got ready=%b busy=%b want %b/%b", t, b2.ready, b2.busy, er, (t < 9));
      end
      n_vec++;
      if (er) begin
        if (b2.rd !== 32'(idx + 1)) begin n_bad++; $display("FAIL b2b_rd idx=%0d got %h want %h", idx, b2.rd, idx + 1); end
        n_vec++;
        idx++;
        if (idx < 3) b2.a = 32'(4 * idx);
        else         b2.req = 1'b0;
      end
    end
  endtask

  task automatic test_req_in_wait;
    int pulses;
    store2(32'h30, 32'h12345678);
    issue2(1'b1, 32'h50, 32'h5);
    pulses = 0;
    @(negedge clk);
    if (b2.ready === 1'b1) pulses++;
    b2.req = 1'b1; b2.we = 1'b1; b2.a = 32'h30; b2.wd = 32'h00000BAD;
    @(negedge clk);
    if (b2.ready === 1'b1) pulses++;
    b2.req = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (b2.ready === 1'b1) pulses++;
    end
    if (pulses !== 1) begin n_bad++; $display("FAIL wait_ignore_pulses got %0d want 1", pulses); end
    n_vec++;
    issue2(1'b0, 32'h30, 32'h0);
    repeat (3) @(negedge clk);
    if (b2.ready !== 1'b1 || b2.rd !== 32'h12345678) begin
      n_bad++; $display("FAIL wait_ignore_word got ready=%b rd=%h want 1/12345678", b2.ready, b2.rd);
    end
    n_vec++;
    @(negedge clk);
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic test_align;
    issue2(1'b1, 32'h12, 32'h1);
    repeat (2) @(negedge clk);
    if (b2.err !== 1'b0) begin n_bad++; $display("FAIL align_err_early got %b want 0", b2.err); end
    n_vec++;
    @(negedge clk);
    if (b2.ready !== 1'b1 || b2.err !== 1'b1) begin
      n_bad++; $display("FAIL align_store got ready=%b err=%b want 1/1", b2.ready, b2.err);
    end
    n_vec++;
    @(negedge clk);
    if (b2.err !== 1'b0) begin n_bad++; $display("FAIL align_err_clear got %b want 0", b2.err); end
    n_vec++;
    issue2(1'b0, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    if (b2.rd !== 32'hDEADBEEF || b2.err !== 1'b0) begin
      n_bad++; $display("FAIL align_word_kept got rd=%h err=%b want deadbeef/0", b2.rd, b2.err);
    end
    n_vec++;
    @(negedge clk);
    issue2(1'b0, 32'h13, 32'h0);
    repeat (3) @(negedge clk);
    if (b2.ready !== 1'b1 || b2.rd !== 32'h0 || b2.err !== 1'b1) begin
      n_bad++; $display("FAIL align_load got ready=%b rd=%h err=%b want 1/0/1", b2.ready, b2.rd, b2.err);
    end
    n_vec++;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_midflight;
    issue3(1'b1, 32'h20, 32'h11);
    repeat (5) @(negedge clk);
    issue3(1'b0, 32'h20, 32'h0);
    repeat (4) @(negedge clk);
    if (b3.ready !== 1'b1 || b3.rd !== 32'h11) begin
      n_bad++; $display("FAIL w3_load got ready=%b rd=%h want 1/11", b3.ready, b3.rd);
    end
    n_vec++;
    repeat (2) @(negedge clk);
    issue3(1'b1, 32'h20, 32'h55);
    @(negedge clk);
    if (b3.busy !== 1'b1) begin n_bad++; $display("FAIL w3_busy got %b want 1", b3.busy); end
    n_vec++;
    @(negedge clk); #1;
    rst_n3 = 1'b0;
    #1;
    if (b3.busy !== 1'b0 || b3.ready !== 1'b0 || b3.rd !== 32'h0) begin
      n_bad++; $display("FAIL async_reset got busy=%b ready=%b rd=%h want 0/0/0", b3.busy, b3.ready, b3.rd);
    end
    n_vec++;
    @(negedge clk);
    rst_n3 = 1'b1;
    repeat (4) @(negedge clk);
    if (b3.busy !== 1'b0 || b3.ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_drop got busy=%b ready=%b want 0/0", b3.busy, b3.ready);
    end
    n_vec++;
    issue3(1'b0, 32'h20, 32'h0);
    repeat (4) @(negedge clk);
    if (b3.ready !== 1'b1 || b3.rd !== 32'h11) begin
      n_bad++; $display("FAIL store_dropped got ready=%b rd=%h want 1/11", b3.ready, b3.rd);
    end
    n_vec++;
  endtask

  task automatic test_w0;
    @(posedge clk); #1;
    b0.req = 1'b1; b0.we = 1'b1; b0.a = 32'h8; b0.wd = 32'd7;
    @(posedge clk);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (b0.ready !== 1'b1 || b0.busy !== 1'b1) begin
        n_bad++; $display("FAIL w0_store t=%0d got ready=%b busy=%b want 1/1", t, b0.ready, b0.busy);
      end
      n_vec++;
      if (t < 2) begin b0.a = 32'h8 + 32'(4 * (t + 1)); b0.wd = 32'(8 + t); end
      else       b0.req = 1'b0;
    end
    @(negedge clk);
    if (b0.ready !== 1'b0 || b0.busy !== 1'b0) begin
      n_bad++; $display("FAIL w0_idle got ready=%b busy=%b want 0/0", b0.ready, b0.busy);
    end
    n_vec++;
    @(posedge clk); #1;
    b0.req = 1'b1; b0.we = 1'b0; b0.a = 32'h8;
    @(posedge clk);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (b0.ready !== 1'b1 || b0.rd !== 32'(7 + t)) begin
        n_bad++; $display("FAIL w0_load t=%0d got ready=%b rd=%h want 1/%h", t, b0.ready, b0.rd, 7 + t);
      end
      n_vec++;
      if (t < 2) b0.a = 32'h8 + 32'(4 * (t + 1));
      else       b0.req = 1'b0;
    end
    @(negedge clk);
    if (b0.ready !== 1'b0 || b0.rd !== 32'd9) begin
      n_bad++; $display("FAIL w0_hold got ready=%b rd=%h want 0/9", b0.ready, b0.rd);
    end
    n_vec++;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_store_load();
    test_aliasing();
    test_back_to_back();
    test_req_in_wait();
`ifdef DMEM_ALIGN_CHECK_EN
    test_align();
`endif
    test_reset_midflight();
    test_w0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
